// File: rtl/secuenciador_lockin_pkg.sv
// Shared state encoding and default timing constants for the lock-in run sequencer.
package secuenciador_lockin_pkg;

    typedef enum logic [2:0] {
        EST_IDLE,
        EST_CLEAR,
        EST_RUN,
        EST_DRAIN,
        EST_DONE
    } estado_t;

    localparam int CICLOS_CLR_DEF    = 2;
    localparam int TIMEOUT_DRAIN_DEF = 64;

endpackage

// File: rtl/contador_muestras.sv
// 32-bit sample counter: synchronous clear has priority, counts on enable, stops at limite.
module contador_muestras (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] limite,
    output logic [31:0] cuenta
);

    logic [31:0] cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (clr) begin
            cuenta_d = '0;
        end else if (en && (cuenta_q < limite)) begin
            cuenta_d = cuenta_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta = cuenta_q;

endmodule

// File: rtl/secuenciador_lockin.sv
// Run sequencer for the lock-in mixer: clears the mixer, forwards a fixed number of
// samples, waits for the mixer outputs to drain and reports completion or fault.
module secuenciador_lockin
    import secuenciador_lockin_pkg::*;
#(
    parameter int CICLOS_CLR    = CICLOS_CLR_DEF,
    parameter int TIMEOUT_DRAIN = TIMEOUT_DRAIN_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] ptos_x_ciclo_in,
    input  logic [15:0] n_ciclos_in,
    input  logic        data_valid_in,
    input  logic        mixer_valid,
    input  logic        ack,
    output logic        mixer_enable,
    output logic        mixer_reset_n,
    output logic [15:0] mixer_ptos_x_ciclo,
    output logic        mixer_data_valid,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] muestras_out
);

    estado_t     estado_q, estado_d;
    logic [15:0] ptos_q, ptos_d;
    logic [31:0] objetivo_q, objetivo_d;
    logic [3:0]  clr_cnt_q, clr_cnt_d;
    logic [15:0] drain_cnt_q, drain_cnt_d;
    logic        error_q, error_d;
    logic        enable_q, enable_d;
    logic        rstn_mix_q, rstn_mix_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        arranque;
    logic        en_salida;
    logic [31:0] cnt_entrada;
    logic [31:0] cnt_salida;

    assign arranque         = (estado_q == EST_IDLE) && start && !abort;
    // Zero-latency gate so the mixer sees the sample in the same cycle it is counted.
    assign mixer_data_valid = (estado_q == EST_RUN) && data_valid_in;
    assign en_salida        = ((estado_q == EST_RUN) || (estado_q == EST_DRAIN)) && mixer_valid;

    contador_muestras u_cnt_entrada (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (arranque),
        .en      (mixer_data_valid),
        .limite  (objetivo_q),
        .cuenta  (cnt_entrada)
    );

    contador_muestras u_cnt_salida (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (arranque),
        .en      (en_salida),
        .limite  (objetivo_q),
        .cuenta  (cnt_salida)
    );

    always_comb begin
        estado_d    = estado_q;
        ptos_d      = ptos_q;
        objetivo_d  = objetivo_q;
        clr_cnt_d   = clr_cnt_q;
        drain_cnt_d = drain_cnt_q;
        error_d     = error_q;

        if (abort && (estado_q != EST_IDLE)) begin
            estado_d = EST_IDLE;
        end else begin
            case (estado_q)
                EST_IDLE: begin
                    if (arranque) begin
                        ptos_d     = ptos_x_ciclo_in;
                        objetivo_d = {16'd0, ptos_x_ciclo_in} * {16'd0, n_ciclos_in};
                        clr_cnt_d  = '0;
                        error_d    = 1'b0;
                        if ((ptos_x_ciclo_in == 16'd0) || (n_ciclos_in == 16'd0)) begin
                            estado_d = EST_DONE;
                            error_d  = 1'b1;
                        end else begin
                            estado_d = EST_CLEAR;
                        end
                    end
                end
                EST_CLEAR: begin
                    if (clr_cnt_q == 4'(CICLOS_CLR - 1)) begin
                        estado_d = EST_RUN;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 4'd1;
                    end
                end
                EST_RUN: begin
                    drain_cnt_d = '0;
                    if (mixer_data_valid && ((cnt_entrada + 32'd1) == objetivo_q)) begin
                        estado_d = EST_DRAIN;
                    end
                end
                EST_DRAIN: begin
                    if (cnt_salida == objetivo_q) begin
                        estado_d = EST_DONE;
                    end else if (drain_cnt_q == 16'(TIMEOUT_DRAIN - 1)) begin
                        estado_d = EST_DONE;
                        error_d  = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 16'd1;
                    end
                end
                EST_DONE: begin
                    if (ack) begin
                        estado_d = EST_IDLE;
                    end
                end
                default: estado_d = EST_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register alongside it.
        enable_d   = (estado_d == EST_RUN) || (estado_d == EST_DRAIN);
        rstn_mix_d = (estado_d != EST_CLEAR);
        busy_d     = (estado_d == EST_CLEAR) || (estado_d == EST_RUN) || (estado_d == EST_DRAIN);
        done_d     = (estado_d == EST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q    <= EST_IDLE;
            ptos_q      <= '0;
            objetivo_q  <= '0;
            clr_cnt_q   <= '0;
            drain_cnt_q <= '0;
            error_q     <= 1'b0;
            enable_q    <= 1'b0;
            rstn_mix_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            ptos_q      <= ptos_d;
            objetivo_q  <= objetivo_d;
            clr_cnt_q   <= clr_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            error_q     <= error_d;
            enable_q    <= enable_d;
            rstn_mix_q  <= rstn_mix_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mixer_enable       = enable_q;
    assign mixer_reset_n      = rstn_mix_q;
    assign mixer_ptos_x_ciclo = ptos_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign muestras_out       = cnt_salida;

endmodule

// File: tb/tb_secuenciador_lockin.sv
// Scoreboard bench for secuenciador_lockin with a delayed-echo mixer model.
module tb_secuenciador_lockin;

    localparam int CICLOS_CLR    = 2;
    localparam int TIMEOUT_DRAIN = 64;

    logic        clock = 1'b0;
    logic        reset_n, start, abort, data_valid_in, ack;
    logic [15:0] ptos_x_ciclo_in, n_ciclos_in;
    logic        mixer_valid, mixer_enable, mixer_reset_n, mixer_data_valid;
    logic [15:0] mixer_ptos_x_ciclo;
    logic        busy, done, error;
    logic [31:0] muestras_out;

    secuenciador_lockin #(
        .CICLOS_CLR    (CICLOS_CLR),
        .TIMEOUT_DRAIN (TIMEOUT_DRAIN)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .start              (start),
        .abort              (abort),
        .ptos_x_ciclo_in    (ptos_x_ciclo_in),
        .n_ciclos_in        (n_ciclos_in),
        .data_valid_in      (data_valid_in),
        .mixer_valid        (mixer_valid),
        .ack                (ack),
        .mixer_enable       (mixer_enable),
        .mixer_reset_n      (mixer_reset_n),
        .mixer_ptos_x_ciclo (mixer_ptos_x_ciclo),
        .mixer_data_valid   (mixer_data_valid),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .muestras_out       (muestras_out)
    );

    always #5 clock = ~clock;

    // Mixer model: echoes each forwarded strobe after a configurable delay, up to a quota.
    logic [7:0]  hist = '0;
    logic [2:0]  idx_dly = 3'd0;
    int unsigned fwd_total = 0;
    int unsigned emit_total = 0;
    int unsigned cuota_abs = 0;
    logic        mv_extra = 1'b0;
    logic        mv_model;

    assign mv_model    = hist[idx_dly] && (emit_total < cuota_abs);
    assign mixer_valid = mv_model | mv_extra;

    always @(posedge clock) begin
        hist <= {hist[6:0], mixer_data_valid};
        if (mixer_data_valid) fwd_total <= fwd_total + 1;
        if (mv_model) emit_total <= emit_total + 1;
    end

    typedef struct {
        int unsigned muestras;
        bit          err;
        int unsigned fwd;
        int unsigned base;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   fin = 1'b0;
    logic done_prev = 1'b0;

    task automatic chk(input string nombre, input longint got, input longint expv);
        n_cmp++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nombre, got, expv, $time);
        end
    endtask

    task automatic ejecutar(input int ptos, input int n, input int dly, input int cuota,
                            input int prob, input bit molestar);
        int unsigned total;
        bit          cfg_err;
        exp_t        e;
        int          ciclos, clr_low, drain, ena_seen;
        bit          pulsado;
        total    = ptos * n;
        cfg_err  = (ptos == 0) || (n == 0);
        ciclos   = 0;
        clr_low  = 0;
        drain    = 0;
        ena_seen = 0;
        pulsado  = 1'b0;
        @(negedge clock);
        idx_dly    = 3'(dly - 1);
        cuota_abs  = emit_total + cuota;
        e.muestras = cfg_err ? 0 : ((cuota < total) ? cuota : total);
        e.err      = cfg_err || (cuota < total);
        e.fwd      = cfg_err ? 0 : total;
        e.base     = fwd_total;
        sb.push_back(e);
        ptos_x_ciclo_in = 16'(ptos);
        n_ciclos_in     = 16'(n);
        start           = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (!done && ciclos < 3000) begin
            if (!mixer_reset_n) clr_low++;
            if (mixer_enable) ena_seen++;
            if (!cfg_err && busy && (fwd_total - e.base == total)) drain++;
            data_valid_in = ($urandom_range(99) < prob);
            start = molestar && mixer_enable && !pulsado;
            if (start) pulsado = 1'b1;
            @(negedge clock);
            ciclos++;
        end
        data_valid_in = 1'b0;
        start         = 1'b0;
        if (!done) begin
            chk("done_timeout", 0, 1);
            return;
        end
        if (cfg_err) begin
            chk("cfg_latency", ciclos, 0);
            chk("cfg_enable_never", ena_seen, 0);
        end else begin
            chk("clear_cycles", clr_low, CICLOS_CLR);
            if (e.err) chk("drain_len", drain, TIMEOUT_DRAIN);
        end
        chk("ptos_held", mixer_ptos_x_ciclo, ptos);
        mv_extra = 1'b1;
        @(negedge clock);
        mv_extra = 1'b0;
        chk("done_ignores_mv", muestras_out, e.muestras);
        chk("done_held", done, 1);
        ack   = 1'b1;
        start = molestar;
        @(negedge clock);
        ack   = 1'b0;
        start = 1'b0;
        chk("idle_after_ack", {busy, done}, 0);
        if (molestar) begin
            repeat (4) @(negedge clock);
            chk("start_with_ack_ignored", {busy, done, mixer_enable}, 0);
        end
        repeat (6) @(negedge clock);
    endtask

    task automatic prueba_abort();
        int unsigned base;
        int          c, mdv_seen, done_seen;
        @(negedge clock);
        idx_dly   = 3'd1;
        cuota_abs = emit_total + 100;
        base      = fwd_total;
        ptos_x_ciclo_in = 16'd4;
        n_ciclos_in     = 16'd4;
        start           = 1'b1;
        @(negedge clock);
        start         = 1'b0;
        data_valid_in = 1'b1;
        c = 0;
        while ((fwd_total - base) < 5 && c < 100) begin
            @(negedge clock);
            c++;
        end
        data_valid_in = 1'b0;
        abort         = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_fwd_count", fwd_total - base, 5);
        chk("abort_busy", busy, 0);
        chk("abort_enable", mixer_enable, 0);
        chk("abort_mix_rstn", mixer_reset_n, 1);
        mdv_seen  = 0;
        done_seen = 0;
        data_valid_in = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (mixer_data_valid) mdv_seen++;
            if (done) done_seen++;
        end
        data_valid_in = 1'b0;
        chk("abort_no_forward", mdv_seen, 0);
        chk("abort_no_done", done_seen, 0);
    endtask

    task automatic prueba_reset_drain();
        int unsigned base;
        int          c;
        @(negedge clock);
        idx_dly   = 3'd0;
        cuota_abs = emit_total + 3;
        base      = fwd_total;
        ptos_x_ciclo_in = 16'd8;
        n_ciclos_in     = 16'd1;
        start           = 1'b1;
        @(negedge clock);
        start         = 1'b0;
        data_valid_in = 1'b1;
        c = 0;
        while ((fwd_total - base) < 8 && c < 100) begin
            @(negedge clock);
            c++;
        end
        data_valid_in = 1'b0;
        repeat (10) @(negedge clock);
        chk("drain_reached_busy", busy, 1);
        chk("drain_partial_count", muestras_out, 3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_enable", mixer_enable, 0);
        chk("rst_async_mix_rstn", mixer_reset_n, 0);
        chk("rst_async_ptos", mixer_ptos_x_ciclo, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_muestras", muestras_out, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_release_mix_rstn", mixer_reset_n, 1);
    endtask

    initial begin
        reset_n         = 1'b0;
        start           = 1'b0;
        abort           = 1'b0;
        ack             = 1'b0;
        data_valid_in   = 1'b0;
        ptos_x_ciclo_in = 16'd0;
        n_ciclos_in     = 16'd0;

        fork
            begin : monitor
                while (!fin) begin
                    @(negedge clock);
                    if (done && !done_prev) begin
                        if (sb.size() == 0) begin
                            chk("sb_unexpected_done", 1, 0);
                        end else begin
                            e_mon = sb.pop_front();
                            chk("sb_muestras", muestras_out, e_mon.muestras);
                            chk("sb_error", error, e_mon.err);
                            chk("sb_forwarded", fwd_total - e_mon.base, e_mon.fwd);
                            chk("sb_busy_at_done", busy, 0);
                            chk("sb_enable_at_done", mixer_enable, 0);
                        end
                    end
                    done_prev = done;
                end
            end
            begin : estimulo
                repeat (3) @(negedge clock);
                chk("rst_enable", mixer_enable, 0);
                chk("rst_mix_rstn", mixer_reset_n, 0);
                chk("rst_ptos", mixer_ptos_x_ciclo, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_error", error, 0);
                chk("rst_muestras", muestras_out, 0);
                reset_n = 1'b1;
                @(negedge clock);
                chk("idle_mix_rstn", mixer_reset_n, 1);

                ejecutar(4, 3, 2, 12, 100, 1'b0);
                ejecutar(0, 5, 1, 0, 100, 1'b0);
                ejecutar(8, 1, 1, 0, 100, 1'b0);
                prueba_abort();
                prueba_reset_drain();
                ejecutar(5, 2, 3, 10, 100, 1'b0);
                ejecutar(3, 2, 3, 6, 100, 1'b1);

                for (int r = 0; r < 12; r++) begin
                    int p, n, d, q, pr;
                    p  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(8, 1));
                    n  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(6, 1));
                    d  = int'($urandom_range(4, 1));
                    q  = ($urandom_range(3) == 0) ? int'($urandom_range(p * n, 0)) : p * n;
                    pr = int'($urandom_range(100, 30));
                    ejecutar(p, n, d, q, pr, $urandom_range(1) == 1);
                end

                repeat (4) @(negedge clock);
                chk("sb_empty", sb.size(), 0);
                fin = 1'b1;
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/secuenciador_lockin.md
SECUENCIADOR_LOCKIN -- requirements
Module: secuenciador_lockin

Interface
REQ-001 Parameter: CICLOS_CLR, 2, cycles mixer_reset_n held low before each run (1..15).
REQ-002 Parameter: TIMEOUT_DRAIN, 64, max cycles in DRAIN waiting for mixer outputs.
REQ-003 Port: clock  in  1  single clock; all logic on rising edge.
REQ-004 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: start  in  1  run request, sampled in IDLE only.
REQ-006 Port: abort  in  1  cancel run, any state.
REQ-007 Port: ptos_x_ciclo_in  in  16  points per reference cycle, latched on accepted start.
REQ-008 Port: n_ciclos_in  in  16  reference cycles per run, latched on accepted start.
REQ-009 Port: data_valid_in  in  1  upstream sample strobe.
REQ-010 Port: mixer_valid  in  1  mixer output valid (data_valid_multiplicacion).
REQ-011 Port: ack  in  1  consumer acknowledge of done.
REQ-012 Port: mixer_enable  out  1  mixer enable.
REQ-013 Port: mixer_reset_n  out  1  mixer/reference-table reset, active-low.
REQ-014 Port: mixer_ptos_x_ciclo  out  16  latched points-per-cycle to mixer.
REQ-015 Port: mixer_data_valid  out  1  gated sample strobe to mixer.
REQ-016 Port: busy  out  1  high in CLEAR, RUN, DRAIN.
REQ-017 Port: done  out  1  high in DONE.
REQ-018 Port: error  out  1  valid while done; config or timeout fault.
REQ-019 Port: muestras_out  out  32  mixer outputs counted in the run.

Function
- REQ-020 FSM states: IDLE, CLEAR, RUN, DRAIN, DONE; state and all outputs except mixer_data_valid are registered.
- REQ-021 IDLE + start (abort low): latch ptos, n_ciclos; objetivo = ptos*n_ciclos (32-bit unsigned, exact); clear both counters and error.
- REQ-022 Accepted start with ptos==0 or n_ciclos==0: go to DONE with error=1, muestras_out=0, no CLEAR.
- REQ-023 Otherwise IDLE->CLEAR; mixer_reset_n=0 for exactly CICLOS_CLR cycles, mixer_enable=0; then RUN.
- REQ-024 RUN: mixer_enable=1, mixer_reset_n=1, mixer_data_valid = data_valid_in (combinational AND with state==RUN, zero-cycle latency).
- REQ-025 Input counter increments per forwarded sample; on the cycle forwarding sample number objetivo, next state DRAIN; no further samples forwarded.
- REQ-026 Output counter increments per mixer_valid in RUN and DRAIN; saturates at objetivo; muestras_out reflects it.
- REQ-027 DRAIN: mixer_enable=1, mixer_data_valid=0; exit to DONE when output count==objetivo (error=0), or after TIMEOUT_DRAIN cycles in DRAIN (error=1).
- REQ-028 DONE: done=1, busy=0, mixer_enable=0, mixer_ptos_x_ciclo held; stay until ack, then IDLE next cycle.
- REQ-029 start outside IDLE is ignored; start and ack together in DONE: go IDLE, start ignored.
- REQ-030 abort in any non-IDLE state: IDLE next cycle, done never asserted, mixer_enable=0, mixer_reset_n=1; abort with start in IDLE: start ignored.
- REQ-031 mixer_valid in IDLE, CLEAR or DONE is ignored.

Reset
- REQ-032 reset_n low (asynchronous, any time incl. mid-run): state IDLE, mixer_enable=0, mixer_reset_n=0, mixer_ptos_x_ciclo=0, busy=0, done=0, error=0, muestras_out=0, counters 0.
- REQ-033 After reset release, mixer_reset_n=1 from the first clock edge in IDLE.

Structure
- REQ-034 Package secuenciador_lockin_pkg holds state enum and default CICLOS_CLR/TIMEOUT_DRAIN constants.
- REQ-035 One sub-module contador_muestras (32-bit enable/clear/saturating counter), instantiated for input and output counts.

Verification
- REQ-036 ptos=4, n=3, data_valid_in continuous, mixer_valid 2 cycles delayed -> 12 forwarded strobes, done=1, muestras_out=12, error=0.
- REQ-037 start with ptos=0, n=5 -> DONE next cycle, error=1, mixer_enable never high, muestras_out=0.
- REQ-038 ptos=8, n=1, mixer_valid never asserted -> DRAIN for 64 cycles, then done=1, error=1, muestras_out=0.
- REQ-039 abort in RUN after 5 of 16 samples -> IDLE next cycle, done stays 0, mixer_data_valid 0 thereafter.
- REQ-040 reset_n low mid-DRAIN -> all outputs at reset values immediately (asynchronous), new start runs normally.
- REQ-041 start pulsed during RUN and together with ack in DONE -> ignored; exactly one run completes.
